div_sched: RTL
==============

# div_sched

Sequencer and two-port arbiter for the shared 32/16 restoring divider. It accepts divide requests from two clients (port A: DIV/IDIV microcode, port B: AAM/aux), grants the divider round-robin and drives the divider's toggle handshake. It also performs the x86 #DE checks (zero divisor, quotient overflow) and corrects the signed remainder so that it follows the dividend sign.

## Interface
Parameters: none.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  request level; held with operands until own done
- dividend_a / dividend_b  in  32  dividend
- divisor_a / divisor_b  in  16  divisor
- signed_a / signed_b  in  1  1 = IDIV semantics
- done_a / done_b  out  1  one-cycle result-valid strobe to the served port
- quo  out  16  quotient, valid while done_x high
- rem  out  16  remainder, valid while done_x high
- err_zero  out  1  divisor was 0 (valid with done)
- err_ovf  out  1  quotient out of range (valid with done)
- busy  out  1  high in any state except IDLE
- div_denom  out  32  to divider dividend input, registered
- div_num  out  16  to divider divisor input, registered
- div_signed  out  1  to divider signed_div, registered
- div_run_in  out  1  divider start toggle
- div_run_out  in  1  divider completion toggle
- div_q / div_r  in  16  divider raw quotient / remainder

## Operation
- States: SYNC (reset state), IDLE, LOAD, WAIT, DONE.
- All outputs reset to 0; state resets to SYNC.
- SYNC: each cycle div_run_in <= div_run_out. Move to IDLE on the first edge where the two are equal. This aborts any divide left in flight by a reset.
- IDLE: sample req_a and req_b.
  - Only one request high: that port wins.
  - Both high: the port not served last wins. The last-served pointer resets to B, so A wins the first tie.
  - On grant, register the winner's operands into div_denom, div_num and div_signed, and record the port.
- Pre-check at grant, using magnitudes (two's-complement negate when signed and the sign bit is set; 0x8000 negates to 0x8000).
  - divisor == 0: go to DONE with err_zero.
  - |dividend|[31:16] >= |divisor|: go to DONE with err_ovf.
  - Otherwise go to LOAD.
- LOAD: the divider captures operands this cycle. At the closing edge toggle div_run_in and go to WAIT.
- div_denom, div_num and div_signed stay stable from grant until the next grant.
- WAIT: when div_run_out == div_run_in, latch the results and go to DONE.
  - Quotient post-check, signed only, with s = dividend[31] ^ divisor[15]:
    - s=0 and div_q[15]=1: err_ovf.
    - s=1 and div_q != 0 and div_q[15]=0: err_ovf.
  - Remainder fix-up, signed only: |r| = s ? -div_r : div_r; rem = dividend[31] ? -|r| : |r|.
  - Unsigned: quo = div_q, rem = div_r.
- DONE: assert done_x for the recorded port for one cycle, then go to IDLE.
  - quo and rem are driven as 0 when either error flag is set.
  - Update the last-served pointer.

## Timing
- Edge 0 is the IDLE edge that grants a request.
- Normal path:
  - edge 0 -> LOAD
  - edge 1 -> WAIT, run_in toggles
  - divider runs edges 2..18
  - edge 19 -> DONE; done_x is high between edge 19 and edge 20
  - edge 20 -> IDLE
  - Latency: 20 cycles, grant to done.
- Error path: edge 0 -> DONE; done_x is high between edge 0 and edge 1. Latency is 1 cycle.
- Requester handshake: the requester deasserts req on the edge that ends its done cycle. req is sampled only in IDLE, so a request still high at edge 21 is a new request.
- Back-to-back: the minimum gap between consecutive grants is 21 cycles (normal) or 2 cycles (error).
- Reset asserted mid-operation: outputs clear immediately and the state goes to SYNC. No done is issued for the aborted request.
- A requester may drop req while busy. The result is still produced and its done strobe is ignored.

## Test plan
- Unsigned: A requests 0x0001_0000 / 0x0002 -> done_a 20 cycles after grant, quo 0x8000, rem 0x0000, no error flags.
- Zero divisor: B requests 0x0000_1234 / 0 -> done_b 1 cycle after grant, err_zero=1, quo=rem=0, div_run_in does not toggle.
- Unsigned pre-overflow: 0x0002_0000 / 0x0002 -> err_ovf=1 after 1 cycle.
- Signed:
  - 0x0000_0007 / 0xFFFE -> quo 0xFFFD, rem 0x0001 (fix-up corrects the divider's 0xFFFF).
  - 0xFFFF_FFF9 / 0x0002 -> quo 0xFFFD, rem 0xFFFF.
- Signed post-overflow:
  - 0x0000_8000 / 0x0001 -> err_ovf after 20 cycles.
  - 0xFFFF_8000 / 0x0001 -> quo 0x8000, no error.
- Arbitration and reset:
  - req_a and req_b rise together -> A served first, then B; ties alternate thereafter.
  - Pulse rst_n low at cycle 10 of a divide -> SYNC realigns div_run_in to div_run_out, and the next request completes with correct results.

Source files
------------

// File: rtl/div_sched.sv
// div_sched: round-robin two-port front end for the shared 32/16 restoring divider.
// Drives the divider toggle handshake, performs #DE checks and signed remainder fix-up.
module div_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [31:0] dividend_a,
   input  logic [31:0] dividend_b,
   input  logic [15:0] divisor_a,
   input  logic [15:0] divisor_b,
   input  logic        signed_a,
   input  logic        signed_b,
   output logic        done_a,
   output logic        done_b,
   output logic [15:0] quo,
   output logic [15:0] rem,
   output logic        err_zero,
   output logic        err_ovf,
   output logic        busy,
   output logic [31:0] div_denom,
   output logic [15:0] div_num,
   output logic        div_signed,
   output logic        div_run_in,
   input  logic        div_run_out,
   input  logic [15:0] div_q,
   input  logic [15:0] div_r
);

   localparam int unsigned DVD_W = 32;
   localparam int unsigned DVS_W = 16;

   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_IDLE = 3'd1,
      ST_LOAD = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   state_e             state_q;
   logic               last_b_q;
   logic               port_b_q;
   logic               run_in_q;
   logic               busy_q;
   logic               done_a_q;
   logic               done_b_q;
   logic               err_zero_q;
   logic               err_ovf_q;
   logic               signed_q;
   logic [DVD_W-1:0]   denom_q;
   logic [DVS_W-1:0]   num_q;
   logic [DVS_W-1:0]   quo_q;
   logic [DVS_W-1:0]   rem_q;

   logic               grant_c;
   logic               pick_b_c;
   logic               win_sgn_c;
   logic [DVD_W-1:0]   win_dvd_c;
   logic [DVS_W-1:0]   win_dvs_c;
   logic [DVD_W-1:0]   abs_dvd_c;
   logic [DVS_W-1:0]   abs_dvs_c;
   logic               pre_zero_c;
   logic               pre_ovf_c;

   logic               s_c;
   logic               post_ovf_c;
   logic [DVS_W-1:0]   r_abs_c;
   logic [DVS_W-1:0]   rem_fix_c;

   // Arbitration: a tie goes to the port that was not served last.
   always_comb begin
      grant_c  = 1'b0;
      pick_b_c = 1'b0;
      if (req_a && req_b) begin
         grant_c  = 1'b1;
         pick_b_c = ~last_b_q;
      end else if (req_a || req_b) begin
         grant_c  = 1'b1;
         pick_b_c = req_b;
      end
      win_dvd_c  = pick_b_c ? dividend_b : dividend_a;
      win_dvs_c  = pick_b_c ? divisor_b  : divisor_a;
      win_sgn_c  = pick_b_c ? signed_b   : signed_a;
      abs_dvd_c  = (win_sgn_c && win_dvd_c[DVD_W-1]) ? DVD_W'(-win_dvd_c) : win_dvd_c;
      abs_dvs_c  = (win_sgn_c && win_dvs_c[DVS_W-1]) ? DVS_W'(-win_dvs_c) : win_dvs_c;
      pre_zero_c = (win_dvs_c == '0);
      pre_ovf_c  = (abs_dvd_c[DVD_W-1 -: DVS_W] >= abs_dvs_c);
   end

   // Signed quotient range check and remainder sign correction on the raw divider result.
   always_comb begin
      s_c        = signed_q & (denom_q[DVD_W-1] ^ num_q[DVS_W-1]);
      post_ovf_c = 1'b0;
      if (signed_q) begin
         post_ovf_c = s_c ? ((div_q != '0) && !div_q[DVS_W-1]) : div_q[DVS_W-1];
      end
      r_abs_c    = s_c ? DVS_W'(-div_r) : div_r;
      rem_fix_c  = (signed_q && denom_q[DVD_W-1]) ? DVS_W'(-r_abs_c) : r_abs_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SYNC;
         last_b_q   <= 1'b1;
         port_b_q   <= 1'b0;
         run_in_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_a_q   <= 1'b0;
         done_b_q   <= 1'b0;
         err_zero_q <= 1'b0;
         err_ovf_q  <= 1'b0;
         signed_q   <= 1'b0;
         denom_q    <= '0;
         num_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
      end else begin
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         case (state_q)
            // Realign the start toggle with the divider so a divide cut off by reset is dropped.
            ST_SYNC: begin
               run_in_q <= div_run_out;
               if (run_in_q == div_run_out) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (grant_c) begin
                  port_b_q <= pick_b_c;
                  denom_q  <= win_dvd_c;
                  num_q    <= win_dvs_c;
                  signed_q <= win_sgn_c;
                  busy_q   <= 1'b1;
                  if (pre_zero_c || pre_ovf_c) begin
                     err_zero_q <= pre_zero_c;
                     err_ovf_q  <= ~pre_zero_c;
                     quo_q      <= '0;
                     rem_q      <= '0;
                     done_a_q   <= ~pick_b_c;
                     done_b_q   <= pick_b_c;
                     state_q    <= ST_DONE;
                  end else begin
                     state_q    <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               run_in_q <= ~run_in_q;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (div_run_out == run_in_q) begin
                  err_zero_q <= 1'b0;
                  err_ovf_q  <= post_ovf_c;
                  quo_q      <= post_ovf_c ? '0 : div_q;
                  rem_q      <= post_ovf_c ? '0 : rem_fix_c;
                  done_a_q   <= ~port_b_q;
                  done_b_q   <= port_b_q;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_b_q <= port_b_q;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_SYNC;
            end
         endcase
      end
   end

   assign done_a     = done_a_q;
   assign done_b     = done_b_q;
   assign quo        = quo_q;
   assign rem        = rem_q;
   assign err_zero   = err_zero_q;
   assign err_ovf    = err_ovf_q;
   assign busy       = busy_q;
   assign div_denom  = denom_q;
   assign div_num    = num_q;
   assign div_signed = signed_q;
   assign div_run_in = run_in_q;

endmodule
